// File: rtl/alu_muldiv.sv
// alu_muldiv: combinational MIPS R-type ALU plus an iterative multiply/divide
// unit that owns HI/LO. Mul/div take WIDTH iterations after the accepting
// edge. The control unit sees a start/busy/done handshake.
module alu_muldiv #(
    parameter int WIDTH = 32,               // power of two, >= 4
    parameter int SHW   = $clog2(WIDTH)     // derived; do not override
) (
    input  logic             clk,
    input  logic             reset,         // async, active low
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [5:0]       aluop,
    input  logic [SHW-1:0]   shamt,
    input  logic             start,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    localparam logic [5:0] OP_SLL  = 6'b000000;
    localparam logic [5:0] OP_SRL  = 6'b000010;
    localparam logic [5:0] OP_SRA  = 6'b000011;
    localparam logic [5:0] OP_MFHI = 6'b010000;
    localparam logic [5:0] OP_MTHI = 6'b010001;
    localparam logic [5:0] OP_MFLO = 6'b010010;
    localparam logic [5:0] OP_MTLO = 6'b010011;
    localparam logic [5:0] OP_MULT = 6'b011000;
    localparam logic [5:0] OP_MULU = 6'b011001;
    localparam logic [5:0] OP_DIV  = 6'b011010;
    localparam logic [5:0] OP_DIVU = 6'b011011;
    localparam logic [5:0] OP_ADD  = 6'b100000;
    localparam logic [5:0] OP_SUB  = 6'b100010;
    localparam logic [5:0] OP_AND  = 6'b100100;
    localparam logic [5:0] OP_OR   = 6'b100101;
    localparam logic [5:0] OP_XOR  = 6'b100110;
    localparam logic [5:0] OP_NOR  = 6'b100111;
    localparam logic [5:0] OP_SLT  = 6'b101010;
    localparam logic [5:0] OP_SLTU = 6'b101011;

    localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    // Sign/corner information captured at the accepting edge and applied
    // at the final edge.
    typedef struct packed {
        logic             neg_lo;  // negate product / quotient
        logic             neg_hi;  // negate remainder (dividend sign)
        logic             dvz;     // divide by zero
        logic [WIDTH-1:0] a_raw;   // original dividend for the dvz case
    } fix_t;

    state_t           state;
    fix_t             fix;
    logic [SHW-1:0]   cnt;
    logic [WIDTH-1:0] hi, lo;
    logic [WIDTH-1:0] acc_hi, acc_lo;   // mul: partial product / multiplier; div: remainder / quotient
    logic [WIDTH-1:0] opb;              // multiplicand or divisor magnitude

    // ---------------- combinational ALU ----------------
    logic slt, sltu;
    assign slt  = $signed(a) < $signed(b);
    assign sltu = a < b;

    // Result mux; unlisted codes (incl. mul/div/MT) give zero.
    always_comb begin
        result = '0;
        case (aluop)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOR:  result = ~(a | b);
            OP_SLT:  result = {{(WIDTH-1){1'b0}}, slt};
            OP_SLTU: result = {{(WIDTH-1){1'b0}}, sltu};
            OP_SLL:  result = b << shamt;
            OP_SRL:  result = b >> shamt;
            OP_SRA:  result = $unsigned($signed(b) >>> shamt);
            OP_MFHI: result = hi;
            OP_MFLO: result = lo;
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

    // ---------------- operand preparation ----------------
    logic             op_signed, op_is_mul, op_is_div, sa, sb;
    logic [WIDTH-1:0] a_mag, b_mag;
    assign op_signed = (aluop == OP_MULT) || (aluop == OP_DIV);
    assign op_is_mul = (aluop == OP_MULT) || (aluop == OP_MULU);
    assign op_is_div = (aluop == OP_DIV)  || (aluop == OP_DIVU);
    assign sa        = op_signed & a[WIDTH-1];
    assign sb        = op_signed & b[WIDTH-1];
    assign a_mag     = sa ? -a : a;
    assign b_mag     = sb ? -b : b;

    // ---------------- one iteration ----------------
    logic [WIDTH:0]   mul_sum, div_sh, div_diff;
    logic             div_ok;
    logic [WIDTH-1:0] it_hi, it_lo;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] quo, rem, fin_hi, fin_lo;

    // Shift-add step and restoring-divide step on magnitudes, then the
    // sign fix-up used only on the last iteration.
    always_comb begin
        mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
        div_sh   = {acc_hi, acc_lo[WIDTH-1]};
        div_diff = div_sh - {1'b0, opb};
        div_ok   = ~div_diff[WIDTH];
        if (state == S_DIV) begin
            it_hi = div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
            it_lo = {acc_lo[WIDTH-2:0], div_ok};
        end else begin
            it_hi = mul_sum[WIDTH:1];
            it_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
        prod = fix.neg_lo ? -{it_hi, it_lo} : {it_hi, it_lo};
        quo  = fix.neg_lo ? -it_lo : it_lo;
        rem  = fix.neg_hi ? -it_hi : it_hi;
        if (state == S_DIV) begin
            fin_hi = fix.dvz ? fix.a_raw : rem;
            fin_lo = fix.dvz ? '1 : quo;
        end else begin
            fin_hi = prod[2*WIDTH-1:WIDTH];
            fin_lo = prod[WIDTH-1:0];
        end
    end

    // Handshake FSM: accept/MT in idle, iterate WIDTH times, then commit HI/LO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            opb    <= '0;
            fix    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (op_is_mul || op_is_div) begin
                            state      <= op_is_div ? S_DIV : S_MUL;
                            busy       <= 1'b1;
                            cnt        <= '0;
                            acc_hi     <= '0;
                            acc_lo     <= a_mag;
                            opb        <= b_mag;
                            fix.neg_lo <= sa ^ sb;
                            fix.neg_hi <= sa;
                            fix.dvz    <= op_is_div && (b == '0);
                            fix.a_raw  <= a;
                        end else if (aluop == OP_MTHI) begin
                            hi <= a;
                        end else if (aluop == OP_MTLO) begin
                            lo <= a;
                        end
                    end
                end
                default: begin
                    acc_hi <= it_hi;
                    acc_lo <= it_lo;
                    cnt    <= cnt + SHW'(1);
                    if (cnt == LAST) begin
                        hi    <= fin_hi;
                        lo    <= fin_lo;
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        cnt   <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv at WIDTH=32 and WIDTH=8.
module tb_alu_muldiv;

    localparam logic [5:0] SLL = 6'b000000, SRL = 6'b000010, SRA = 6'b000011;
    localparam logic [5:0] MFHI = 6'b010000, MTHI = 6'b010001;
    localparam logic [5:0] MFLO = 6'b010010, MTLO = 6'b010011;
    localparam logic [5:0] MULT = 6'b011000, MULTU = 6'b011001;
    localparam logic [5:0] DIV = 6'b011010, DIVU = 6'b011011;
    localparam logic [5:0] ADD = 6'b100000, SUB = 6'b100010, AND_ = 6'b100100;
    localparam logic [5:0] OR_ = 6'b100101, XOR_ = 6'b100110, NOR_ = 6'b100111;
    localparam logic [5:0] SLT = 6'b101010, SLTU = 6'b101011;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] a = '0, b = '0, result;
    logic [5:0]  aluop = ADD;
    logic [4:0]  shamt = '0;
    logic        start = 1'b0, zero, busy, done;

    logic [7:0]  a8 = '0, b8 = '0, result8;
    logic [5:0]  aluop8 = ADD;
    logic [2:0]  shamt8 = '0;
    logic        start8 = 1'b0, zero8, busy8, done8;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    alu_muldiv #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .aluop(aluop), .shamt(shamt),
        .start(start), .result(result), .zero(zero), .busy(busy), .done(done)
    );

    alu_muldiv #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .a(a8), .b(b8), .aluop(aluop8), .shamt(shamt8),
        .start(start8), .result(result8), .zero(zero8), .busy(busy8), .done(done8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic comb(input string tag, input logic [5:0] op, input logic [31:0] ia,
                        input logic [31:0] ib, input logic [4:0] sh,
                        input logic [31:0] exp, input logic expz);
        aluop = op; a = ia; b = ib; shamt = sh;
        #1;
        chk(tag, 64'(result), 64'(exp));
        chk({tag, "_zero"}, 64'(zero), 64'(expz));
    endtask

    // Launch a mul/div, check WIDTH busy cycles, a single-cycle done, then HI/LO.
    task automatic muldiv(input string tag, input logic [5:0] op, input logic [31:0] ia,
                          input logic [31:0] ib, input logic [31:0] ehi, input logic [31:0] elo);
        int n;
        aluop = op; a = ia; b = ib; start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            step();
        end
        chk({tag, "_busycyc"}, 64'(n), 64'd32);
        chk({tag, "_done"}, 64'(done), 64'd1);
        step();
        chk({tag, "_done_clr"}, 64'(done), 64'd0);
        aluop = MFHI; #1;
        chk({tag, "_hi"}, 64'(result), 64'(ehi));
        aluop = MFLO; #1;
        chk({tag, "_lo"}, 64'(result), 64'(elo));
    endtask

    initial begin
        int n;
        int ndone;

        // reset state
        reset = 1'b0;
        repeat (2) step();
        aluop = MFHI; #1;
        chk("rst_hi", 64'(result), 64'd0);
        chk("rst_hi_zero", 64'(zero), 64'd1);
        aluop = MFLO; #1;
        chk("rst_lo", 64'(result), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        reset = 1'b1;
        step();

        // combinational sweep
        comb("add",  ADD,  32'h7FFFFFFF, 32'h1, 0, 32'h80000000, 1'b0);
        comb("sub",  SUB,  32'h5, 32'h5, 0, 32'h0, 1'b1);
        comb("slt",  SLT,  32'hFFFFFFFF, 32'h1, 0, 32'h1, 1'b0);
        comb("sltu", SLTU, 32'hFFFFFFFF, 32'h1, 0, 32'h0, 1'b1);
        comb("sra",  SRA,  32'h0, 32'h80000000, 4, 32'hF8000000, 1'b0);
        comb("srl",  SRL,  32'h0, 32'h80000000, 4, 32'h08000000, 1'b0);
        comb("sll",  SLL,  32'h0, 32'h00000001, 31, 32'h80000000, 1'b0);
        comb("nor",  NOR_, 32'h0, 32'h0, 0, 32'hFFFFFFFF, 1'b0);
        comb("and",  AND_, 32'hF0F0FF00, 32'h0FF0F0F0, 0, 32'h00F0F000, 1'b0);
        comb("or",   OR_,  32'hF0000000, 32'h0000000F, 0, 32'hF000000F, 1'b0);
        comb("xor",  XOR_, 32'hFFFF0000, 32'hFF00FF00, 0, 32'h00FFFF00, 1'b0);
        comb("mult_code", MULT, 32'h3, 32'h5, 0, 32'h0, 1'b1);

        // multiply / divide
        muldiv("mult",  MULT,  32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFA);
        muldiv("multu", MULTU, 32'hFFFFFFFE, 32'h3, 32'h00000002, 32'hFFFFFFFA);
        muldiv("div_n7_2", DIV, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        muldiv("divu_100_7", DIVU, 32'd100, 32'd7, 32'h00000002, 32'h0000000E);
        muldiv("div_7_n2", DIV, 32'h7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
        muldiv("div_by0", DIV, 32'h00001234, 32'h0, 32'h00001234, 32'hFFFFFFFF);
        muldiv("div_ovf", DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

        // start during busy ignored; MFLO during busy gives old LO
        aluop = MULTU; a = 32'd3; b = 32'd5; start = 1'b1;
        step();
        start = 1'b0; aluop = MFLO; #1;
        chk("busy_mflo_old", 64'(result), 64'h80000000);
        chk("busy_set", 64'(busy), 64'd1);
        repeat (4) step();
        aluop = DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
        step();
        start = 1'b0; aluop = MFLO;
        ndone = 0;
        for (int i = 0; i < 50; i++) begin
            if (done) ndone++;
            step();
        end
        chk("busy_ndone", 64'(ndone), 64'd1);
        aluop = MFHI; #1;
        chk("busy_hi", 64'(result), 64'h0);
        aluop = MFLO; #1;
        chk("busy_lo", 64'(result), 64'hF);

        // reset mid-multiply
        aluop = MULT; a = 32'hFFFFFFFE; b = 32'h3; start = 1'b1;
        step();
        start = 1'b0;
        repeat (10) step();
        reset = 1'b0; aluop = MFHI; #1;
        chk("rmid_busy", 64'(busy), 64'd0);
        chk("rmid_done", 64'(done), 64'd0);
        chk("rmid_hi", 64'(result), 64'd0);
        aluop = MFLO; #1;
        chk("rmid_lo", 64'(result), 64'd0);
        step();
        reset = 1'b1;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) ndone++;
            step();
        end
        chk("rmid_nodone", 64'(ndone), 64'd0);

        // MTHI / MTLO
        ndone = 0;
        aluop = MTHI; a = 32'hCAFEBABE; start = 1'b1;
        step();
        if (busy || done) ndone++;
        aluop = MTLO; a = 32'h12345678;
        step();
        if (busy || done) ndone++;
        start = 1'b0; aluop = MFHI;
        step();
        if (busy || done) ndone++;
        chk("mt_hi", 64'(result), 64'hCAFEBABE);
        aluop = MFLO; #1;
        chk("mt_lo", 64'(result), 64'h12345678);
        chk("mt_quiet", 64'(ndone), 64'd0);

        // WIDTH=8 instance
        aluop8 = MULTU; a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
        step();
        start8 = 1'b0;
        n = 0;
        while (busy8 && n < 100) begin
            n++;
            step();
        end
        chk("w8_busycyc", 64'(n), 64'd8);
        chk("w8_done", 64'(done8), 64'd1);
        aluop8 = MFHI; #1;
        chk("w8_hi", 64'(result8), 64'hFE);
        aluop8 = MFLO; #1;
        chk("w8_lo", 64'(result8), 64'h01);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Parametrised successor to the processor's single-cycle ALU. It performs all MIPS R-type arithmetic, logic, compare and shift operations combinationally, and adds an iterative multiply/divide unit that owns the HI/LO register pair. It uses a start/busy/done handshake so the control unit can stall on MFHI/MFLO. It sits in the execute stage between the register file read ports and the result multiplexer.

## Interface
- WIDTH, 32, datapath width in bits; must be ≥ 4 and a power of two
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override)

- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- a  in  WIDTH  operand A (rs)
- b  in  WIDTH  operand B (rt)
- aluop  in  6  operation select (MIPS funct encoding, below)
- shamt  in  SHW  shift amount for SLL/SRL/SRA
- start  in  1  launches MULT/MULTU/DIV/DIVU or commits MTHI/MTLO; sampled at rising edge
- result  out  WIDTH  combinational result
- zero  out  1  result == 0
- busy  out  1  multiply/divide in progress
- done  out  1  one-cycle pulse when HI/LO have just been updated by mul/div

## Operation
- Combinational ops, result independent of start/busy:
  - 100000 ADD, 100010 SUB: modulo 2^WIDTH, no overflow trap
  - 100100 AND, 100101 OR, 100110 XOR, 100111 NOR
  - 101010 SLT (signed), 101011 SLTU: result 1 or 0, zero-extended
  - 000000 SLL b<<shamt, 000010 SRL b>>shamt logical, 000011 SRA b>>>shamt arithmetic
  - 010000 MFHI → HI, 010010 MFLO → LO
  - every other code, including mul/div/MT codes, → result 0
- Sequential ops, accepted only when start=1 and busy=0 at an edge:
  - 011000 MULT, 011001 MULTU: {HI,LO} = a × b, 2·WIDTH-bit product, signed or unsigned
  - 011010 DIV, 011011 DIVU: LO = quotient, HI = remainder
  - Signed divide truncates toward zero. Remainder takes the sign of the dividend.
  - 010001 MTHI: HI ← a. 010011 MTLO: LO ← a. Both take effect at the accepting edge, with no busy and no done.
  - start with any other aluop: ignored
- Implementation: shift-add multiplier and restoring divider, one bit per cycle, on operand magnitudes. The sign fix-up is applied at the final edge.
- Divide by zero (signed or unsigned): HI = a, LO = all ones; normal latency.
- DIV of most-negative by −1: LO = most-negative, HI = 0.
- start while busy=1: ignored; the operation in flight is unaffected.
- MFHI/MFLO while busy=1 return the previous HI/LO. The control unit must stall on busy.

## Timing
- Reset (reset=0): HI=LO=0, busy=0, done=0, iteration counter=0, any operation aborted. With aluop=MFHI or MFLO, result=0.
- Edge E0 accepts the mul/div: operands and signs latch, busy=1 from E0.
- Edges E1…E(WIDTH) are iterations. At E(WIDTH), HI/LO are written, busy←0 and done←1.
- done stays high for exactly one cycle and clears at E(WIDTH+1).
- busy is high for exactly WIDTH cycles. New HI/LO are readable via MFHI/MFLO in the cycle after E(WIDTH).
- A start accepted at E(WIDTH+1) is legal, so back-to-back operations are spaced WIDTH+1 edges apart.
- Reset asserted mid-operation clears everything. No done pulse follows, and HI/LO read 0.
- zero follows result combinationally in every cycle.

## Test plan
- WIDTH=32 combinational sweep:
  - ADD 7FFFFFFF+1 → 80000000, zero=0
  - SUB 5−5 → 0, zero=1
  - SLT FFFFFFFF,1 → 1; SLTU FFFFFFFF,1 → 0
  - SRA 80000000 by 4 → F8000000
  - NOR 0,0 → FFFFFFFF
- Multiply:
  - MULT FFFFFFFE×3 with start → busy for 32 cycles, done one-cycle pulse, then MFHI=FFFFFFFF, MFLO=FFFFFFFA
  - MULTU of the same operands → HI=00000002, LO=FFFFFFFA
- Divide:
  - DIV −7/2 → LO=FFFFFFFD, HI=FFFFFFFF
  - DIVU 100/7 → LO=0000000E, HI=00000002
  - DIV 7/−2 → LO=FFFFFFFD, HI=00000001
- Corners:
  - DIV 00001234/0 → HI=00001234, LO=FFFFFFFF
  - DIV 80000000/FFFFFFFF → LO=80000000, HI=0
- Handshake:
  - A second start during busy is ignored (result matches the first operation, single done pulse).
  - MFLO during busy returns the old LO.
  - reset low at cycle 10 of a MULT → busy=0, done=0, HI=LO=0, no later done.
- MTHI/MTLO:
  - MTHI a=CAFEBABE and MTLO a=12345678, each with start → next cycle MFHI=CAFEBABE, MFLO=12345678, busy and done never assert.
  - Repeat with WIDTH=8: MULTU FF×FF → HI=FE, LO=01 after 8 busy cycles.
